muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: 32 shift-add or restoring-divide steps
// on operand magnitudes, then a one-cycle sign fixup. Fixed 33-cycle latency.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  ALU_OPCODE,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  localparam int W = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  typedef struct packed {
    logic [2:0]   op;
    logic         neg_main;  // negate product / quotient
    logic         neg_rem;   // negate remainder (dividend sign)
    logic         div_zero;
    logic [W-1:0] a_raw;     // REM/REMU by zero returns the dividend as given
  } ctx_t;

  state_t         state;
  ctx_t           ctx;
  logic [5:0]     cnt;
  logic [2*W-1:0] acc;       // mul: product; div: {remainder, quotient}
  logic [W-1:0]   opnd;      // mul: multiplicand; div: divisor

  // request decode and operand magnitudes
  logic [2:0]   f;
  logic         a_is_sgn, b_is_sgn, a_sgn, b_sgn, accept;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    f        = ALU_OPCODE[2:0];
    a_is_sgn = (f == 3'b001) || (f == 3'b011) || (f == 3'b100) || (f == 3'b110);
    b_is_sgn = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    a_sgn    = a_is_sgn & DATA1[W-1];
    b_sgn    = b_is_sgn & DATA2[W-1];
    a_mag    = a_sgn ? -DATA1 : DATA1;
    b_mag    = b_sgn ? -DATA2 : DATA2;
    accept   = START && (ALU_OPCODE[4:3] == 2'b01) && !FLUSH;
  end

  // one iteration step of each algorithm
  logic [W:0]     mul_sum, r_sh;
  logic [W-1:0]   r_diff;
  logic           q_ok;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc[W-1:1]};
    r_sh     = {acc[2*W-1:W], acc[W-1]};
    q_ok     = (r_sh >= {1'b0, opnd});
    // remainder stays below the divisor, so the low W bits hold the exact difference
    r_diff   = r_sh[W-1:0] - opnd;
    div_next = {(q_ok ? r_diff : r_sh[W-1:0]), acc[W-2:0], q_ok};
  end

  // sign fixup and special cases; signed overflow falls out of magnitude math
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, res_fin;

  always_comb begin
    prod_fix = ctx.neg_main ? -acc : acc;
    quo_fix  = ctx.neg_main ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = ctx.neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    res_fin  = prod_fix[W-1:0];
    case (ctx.op)
      3'b000:                 res_fin = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_fix[2*W-1:W];
      3'b100, 3'b101:         res_fin = ctx.div_zero ? {W{1'b1}} : quo_fix;
      default:                res_fin = ctx.div_zero ? ctx.a_raw : rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      ctx    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= CALC;
            BUSY         <= 1'b1;
            cnt          <= '0;
            ctx.op       <= f;
            ctx.neg_main <= (f != 3'b000) && (a_sgn ^ b_sgn);
            ctx.neg_rem  <= a_sgn;
            ctx.div_zero <= (DATA2 == '0);
            ctx.a_raw    <= DATA1;
            acc          <= {{W{1'b0}}, (f[2] ? a_mag : b_mag)};
            opnd         <= f[2] ? b_mag : a_mag;
          end
        end
        CALC: begin
          if (FLUSH) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            acc <= ctx.op[2] ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          if (!FLUSH) begin
            RESULT <= res_fin;
            DONE   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and randomized RV32M ops against a 64-bit
// arithmetic reference, plus handshake, flush and reset scenarios.
module tb_muldiv_unit;

  logic        CLK, RESET, START, FLUSH, BUSY, DONE;
  logic [4:0]  ALU_OPCODE;
  logic [31:0] DATA1, DATA2, RESULT;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_last;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd2, OP_MULHSU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ALU_OPCODE(ALU_OPCODE),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: got still running want finished");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = 0;
    case (op)
      OP_MUL:    begin r = ua * ub; return r[31:0];  end
      OP_MULH:   begin r = sa * sb; return r[63:32]; end
      OP_MULHU:  begin r = ua * ub; return r[63:32]; end
      OP_MULHSU: begin r = sa * ub; return r[63:32]; end
      OP_DIV:    begin if (b == 0) return 32'hFFFFFFFF; r = sa / sb; return r[31:0]; end
      OP_DIVU:   begin if (b == 0) return 32'hFFFFFFFF; r = ua / ub; return r[31:0]; end
      OP_REM:    begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default:   begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op right away; returns result, DONE latency and whether BUSY/DONE
  // behaved (BUSY high every cycle before DONE, low in the DONE cycle).
  // Inputs are scrambled while busy to exercise operand latching.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit bok);
    ALU_OPCODE = {2'b01, op};
    DATA1 = a;
    DATA2 = b;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    bok = (BUSY === 1'b1) && (DONE === 1'b0);
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        lat = k;
        res = RESULT;
        if (BUSY !== 1'b0) bok = 1'b0;
        break;
      end
      if (BUSY !== 1'b1) bok = 1'b0;
      DATA1 = $urandom;
      DATA2 = $urandom;
      ALU_OPCODE = 5'($urandom);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", DONE); end
    checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 00000000", RESULT); end
    RESET = 1'b0;
    exp_last = 32'h0;
  endtask

  task automatic test_mul();
    logic [2:0]  ops[4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] as[4]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[4]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex[4]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] r; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bok);
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL mul[%0d] result: got %h want %h", i, r, ex[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL mul[%0d] latency: got %0d want 33", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL mul[%0d] busy/done: got bad want ok", i); end
      exp_last = ex[i];
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd2, 32'd7};
    logic [31:0] ex[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
    logic [31:0] r; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bok);
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL div[%0d] result: got %h want %h", i, r, ex[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL div[%0d] latency: got %0d want 33", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL div[%0d] busy/done: got bad want ok", i); end
      exp_last = ex[i];
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops[6] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM};
    logic [31:0] as[6]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9};
    logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] ex[6]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] r; int lat; bit bok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bok);
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL special[%0d] result: got %h want %h", i, r, ex[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL special[%0d] latency: got %0d want 33", i, lat); end
      exp_last = ex[i];
    end
  endtask

  // consecutive run_op calls issue START in the DONE cycle: one op per 34 cycles
  task automatic test_random();
    logic [31:0] r, a, b, ex; logic [2:0] op; int lat; bit bok;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a  = rnd_opnd();
      b  = rnd_opnd();
      ex = ref_model(op, a, b);
      run_op(op, a, b, r, lat, bok);
      checks++; if (r !== ex) begin errors++; $display("FAIL random[%0d] op%0d %h,%h: got %h want %h", i, op, a, b, r, ex); end
      checks++; if (lat != 33) begin errors++; $display("FAIL random[%0d] latency: got %0d want 33", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL random[%0d] busy/done: got bad want ok", i); end
      exp_last = ex;
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0, first = -1;
    logic [31:0] r = 'x;
    ALU_OPCODE = {2'b01, OP_MUL}; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (k == 4) begin
        ALU_OPCODE = {2'b01, OP_DIV}; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
      end
      if (DONE === 1'b1) begin
        dones++;
        if (first < 0) begin first = k; r = RESULT; end
      end
    end
    START = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_start dones: got %0d want 1", dones); end
    checks++; if (first != 33) begin errors++; $display("FAIL busy_start latency: got %0d want 33", first); end
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL busy_start result: got %h want 0000000c", r); end
    exp_last = 32'd12;
  endtask

  task automatic test_bad_opcode();
    bit saw_busy = 0, saw_done = 0;
    logic [4:0] bad[3] = '{5'b00000, 5'b10100, 5'b00111};
    for (int i = 0; i < 3; i++) begin
      ALU_OPCODE = bad[i]; DATA1 = $urandom; DATA2 = $urandom; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int k = 0; k < 36; k++) begin
        if (BUSY !== 1'b0) saw_busy = 1;
        if (DONE !== 1'b0) saw_done = 1;
        @(posedge CLK); #1;
      end
    end
    checks++; if (saw_busy) begin errors++; $display("FAIL bad_opcode busy: got 1 want 0"); end
    checks++; if (saw_done) begin errors++; $display("FAIL bad_opcode done: got 1 want 0"); end
    checks++; if (RESULT !== exp_last) begin errors++; $display("FAIL bad_opcode result: got %h want %h", RESULT, exp_last); end
  endtask

  task automatic test_flush();
    bit saw_done;
    // flush during CALC, sampled at T+11
    ALU_OPCODE = {2'b01, OP_MUL}; DATA1 = 32'd9; DATA2 = 32'd9; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_calc busy: got %b want 0", BUSY); end
    saw_done = 0;
    repeat (40) begin @(posedge CLK); #1; if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1; end
    checks++; if (saw_done) begin errors++; $display("FAIL flush_calc done: got activity want idle"); end
    checks++; if (RESULT !== exp_last) begin errors++; $display("FAIL flush_calc result: got %h want %h", RESULT, exp_last); end

    // flush sampled on the FIN edge (T+33)
    ALU_OPCODE = {2'b01, OP_DIVU}; DATA1 = 32'd77; DATA2 = 32'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (32) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL flush_fin busy/done: got %b%b want 00", BUSY, DONE); end
    checks++; if (RESULT !== exp_last) begin errors++; $display("FAIL flush_fin result: got %h want %h", RESULT, exp_last); end

    // FLUSH and START together in IDLE: START dropped
    ALU_OPCODE = {2'b01, OP_MUL}; DATA1 = 32'd5; DATA2 = 32'd5; START = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    saw_done = 0;
    repeat (40) begin if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1; @(posedge CLK); #1; end
    checks++; if (saw_done) begin errors++; $display("FAIL flush_start: got activity want idle"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; bit bok;
    ALU_OPCODE = {2'b01, OP_MULHU}; DATA1 = 32'hDEADBEEF; DATA2 = 32'h12345678; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (19) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_mid done: got %b want 0", DONE); end
    checks++; if (RESULT !== 32'h0) begin errors++; $display("FAIL reset_mid result: got %h want 00000000", RESULT); end
    run_op(OP_DIVU, 32'd1000, 32'd10, r, lat, bok);
    checks++; if (r !== 32'd100) begin errors++; $display("FAIL reset_mid fresh result: got %h want 00000064", r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL reset_mid fresh latency: got %0d want 33", lat); end
    exp_last = 32'd100;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    ALU_OPCODE = '0; DATA1 = '0; DATA2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_while_busy();
    test_bad_opcode();
    test_flush();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
